// File: rtl/fc_sequencer.sv
// -----------------------------------------------------------------------------
// fc_sequencer
//
// Control sequencer for the fully-connected layer datapath. A rising edge on
// `start` launches one run: the weight ROM and feature buffer are walked in
// lock-step, one MAC beat per cycle, and the MAC enable/clear strobes plus the
// output-register write strobe are generated through two tag pipelines that
// model the memory and MAC latencies.
//
// Optional feature (macro FC_ARGMAX_EN):
//   defined   - tracks the signed maximum of the written node results and
//               presents the winning node index on class_idx from the done
//               cycle onward (ties keep the lower index).
//   undefined - no compare logic; class_idx is tied to 0.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-low reset
//   start        in   run request level; only a rising edge starts a run
//   weight_addr  out  weight ROM address (node*CHUNKS + chunk)
//   weight_en    out  weight ROM read enable
//   feat_addr    out  feature buffer address (chunk)
//   feat_en      out  feature buffer read enable
//   mac_en       out  MAC lanes consume this cycle's ROM/buffer data
//   mac_clr      out  with mac_en: accumulator loads instead of adding
//   bias_sel     out  node index of the current mac_en beat
//   acc_result   in   signed biased node sum, valid with out_we
//   out_we       out  output register write strobe
//   out_idx      out  output register index for out_we
//   busy         out  run in progress
//   done         out  one-cycle completion pulse
//   class_idx    out  argmax node index (0 when FC_ARGMAX_EN is undefined)
// -----------------------------------------------------------------------------
module fc_sequencer #(
   parameter int datawidth      = 16,
   parameter int input_nodes    = 784,
   parameter int output_nodes   = 2,
   parameter int Mult_Add_Units = 16,
   parameter int MEM_LATENCY    = 1,
   parameter int MAC_LATENCY    = 2,
   localparam int CHUNKS = input_nodes / Mult_Add_Units,
   localparam int N      = CHUNKS * output_nodes,
   localparam int AW     = $clog2(N),
   localparam int FW     = $clog2(CHUNKS),
   localparam int NW     = $clog2(output_nodes)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   output logic [AW-1:0]               weight_addr,
   output logic                        weight_en,
   output logic [FW-1:0]               feat_addr,
   output logic                        feat_en,
   output logic                        mac_en,
   output logic                        mac_clr,
   output logic [NW-1:0]               bias_sel,
   input  logic signed [datawidth-1:0] acc_result,
   output logic                        out_we,
   output logic [NW-1:0]               out_idx,
   output logic                        busy,
   output logic                        done,
   output logic [NW-1:0]               class_idx
);

   if (input_nodes % Mult_Add_Units != 0) begin : g_chk_div
      $error("fc_sequencer: input_nodes must be a multiple of Mult_Add_Units");
   end
   if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_chk_mem
      $error("fc_sequencer: MEM_LATENCY must be within 1..4");
   end
   if (MAC_LATENCY < 1 || MAC_LATENCY > 4) begin : g_chk_mac
      $error("fc_sequencer: MAC_LATENCY must be within 1..4");
   end

   localparam logic [AW-1:0] K_LAST     = AW'(N - 1);
   localparam logic [FW-1:0] CHUNK_LAST = FW'(CHUNKS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t         state, state_nxt;
   logic           start_q;
   logic [AW-1:0]  k_cnt;
   logic [FW-1:0]  chunk_cnt;
   logic [NW-1:0]  node_cnt;
   logic           issuing;

   // Memory-latency tag pipeline: index 0 is loaded by the issuing beat,
   // index MEM_LATENCY-1 lines up with the ROM/buffer data.
   logic [MEM_LATENCY-1:0] mem_vld_p;
   logic [MEM_LATENCY-1:0] mem_first_p;
   logic [MEM_LATENCY-1:0] mem_last_p;
   logic [NW-1:0]          mem_node_p [MEM_LATENCY];

   // MAC-latency tag pipeline: carries only last-chunk tags toward out_we.
   logic [MAC_LATENCY-1:0] mac_vld_p;
   logic [NW-1:0]          mac_node_p [MAC_LATENCY];

   logic          mem_out_vld;
   logic          mem_out_last;
   logic [NW-1:0] mem_out_node;
   logic          mac_in_vld;
   logic          drain_empty_nxt;

   assign issuing      = (state == S_ISSUE);
   assign mem_out_vld  = mem_vld_p[MEM_LATENCY-1];
   assign mem_out_last = mem_last_p[MEM_LATENCY-1];
   assign mem_out_node = mem_node_p[MEM_LATENCY-1];
   assign mac_in_vld   = mem_out_vld & mem_out_last;

   // Both pipelines will hold no tag after the coming edge. Looking one edge
   // ahead lets done land in the cycle right after the final out_we.
   always_comb begin
      drain_empty_nxt = !mac_in_vld;
      for (int i = 0; i < MEM_LATENCY - 1; i++) begin
         if (mem_vld_p[i]) drain_empty_nxt = 1'b0;
      end
      for (int i = 0; i < MAC_LATENCY - 1; i++) begin
         if (mac_vld_p[i]) drain_empty_nxt = 1'b0;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start && !start_q) state_nxt = S_ISSUE;
         S_ISSUE: if (k_cnt == K_LAST)   state_nxt = S_DRAIN;
         S_DRAIN: if (drain_empty_nxt)   state_nxt = S_DONE;
         S_DONE:                         state_nxt = S_IDLE;
         default:                        state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         start_q   <= 1'b0;
         k_cnt     <= '0;
         chunk_cnt <= '0;
         node_cnt  <= '0;
         mem_vld_p <= '0;
         mac_vld_p <= '0;
      end else begin
         state   <= state_nxt;
         start_q <= start;
         if (issuing) begin
            if (k_cnt == K_LAST) begin
               k_cnt     <= '0;
               chunk_cnt <= '0;
               node_cnt  <= '0;
            end else begin
               k_cnt <= k_cnt + AW'(1);
               if (chunk_cnt == CHUNK_LAST) begin
                  chunk_cnt <= '0;
                  node_cnt  <= node_cnt + NW'(1);
               end else begin
                  chunk_cnt <= chunk_cnt + FW'(1);
               end
            end
         end
         // stage boundary: issue -> memory tag pipeline -> MAC tag pipeline
         mem_vld_p[0] <= issuing;
         for (int i = 1; i < MEM_LATENCY; i++) mem_vld_p[i] <= mem_vld_p[i-1];
         mac_vld_p[0] <= mac_in_vld;
         for (int i = 1; i < MAC_LATENCY; i++) mac_vld_p[i] <= mac_vld_p[i-1];
      end
   end

   // Tag payloads are qualified by the valid bits above and need no reset.
   always_ff @(posedge clk) begin
      mem_first_p[0] <= (chunk_cnt == '0);
      mem_last_p[0]  <= (chunk_cnt == CHUNK_LAST);
      mem_node_p[0]  <= node_cnt;
      for (int i = 1; i < MEM_LATENCY; i++) begin
         mem_first_p[i] <= mem_first_p[i-1];
         mem_last_p[i]  <= mem_last_p[i-1];
         mem_node_p[i]  <= mem_node_p[i-1];
      end
      mac_node_p[0] <= mem_out_node;
      for (int i = 1; i < MAC_LATENCY; i++) mac_node_p[i] <= mac_node_p[i-1];
   end

   // Counters return to zero when issue ends, so the addresses read 0 outside
   // a run without extra gating.
   assign weight_addr = k_cnt;
   assign weight_en   = issuing;
   assign feat_addr   = chunk_cnt;
   assign feat_en     = issuing;
   assign mac_en      = mem_out_vld;
   assign mac_clr     = mem_out_vld & mem_first_p[MEM_LATENCY-1];
   assign bias_sel    = mem_out_vld ? mem_out_node : '0;
   assign out_we      = mac_vld_p[MAC_LATENCY-1];
   assign out_idx     = out_we ? mac_node_p[MAC_LATENCY-1] : '0;
   assign busy        = (state == S_ISSUE) || (state == S_DRAIN);
   assign done        = (state == S_DONE);

`ifdef FC_ARGMAX_EN
   logic signed [datawidth-1:0] max_val;
   logic [NW-1:0]               best_idx;
   logic [NW-1:0]               best_idx_nxt;
   logic                        take_new;

   // Node 0 always seeds the maximum; later nodes must be strictly greater.
   always_comb begin
      take_new     = out_we && ((out_idx == '0) || (acc_result > max_val));
      best_idx_nxt = take_new ? out_idx : best_idx;
   end

   always_ff @(posedge clk) begin
      if (take_new) max_val <= acc_result;
   end

   // class_idx is loaded on the edge into DONE, folding in the final node's
   // result that is being written in that same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         best_idx  <= '0;
         class_idx <= '0;
      end else begin
         best_idx <= best_idx_nxt;
         if (state == S_DRAIN && state_nxt == S_DONE) class_idx <= best_idx_nxt;
      end
   end
`else
   logic unused_acc;
   assign unused_acc = ^acc_result;
   assign class_idx  = '0;
`endif

endmodule

// File: tb/tb_fc_sequencer.sv
`timescale 1ns/1ps
module tb_fc_sequencer;

   logic clk = 1'b0;
   logic reset;
   logic start;
   always #5 clk = ~clk;

   logic signed [15:0] acc0, acc1;
   logic signed [15:0] acc_res, acc_res3;

   // default-latency instance
   logic [6:0] weight_addr;
   logic       weight_en;
   logic [5:0] feat_addr;
   logic       feat_en, mac_en, mac_clr;
   logic [0:0] bias_sel, out_idx, class_idx;
   logic       out_we, busy, done;

   // MEM_LATENCY=3, MAC_LATENCY=1 instance
   logic [6:0] weight_addr3;
   logic       weight_en3;
   logic [5:0] feat_addr3;
   logic       feat_en3, mac_en3, mac_clr3;
   logic [0:0] bias_sel3, out_idx3, class_idx3;
   logic       out_we3, busy3, done3;

   assign acc_res  = out_idx[0]  ? acc1 : acc0;
   assign acc_res3 = out_idx3[0] ? acc1 : acc0;

   fc_sequencer dut (
      .clk(clk), .reset(reset), .start(start),
      .weight_addr(weight_addr), .weight_en(weight_en),
      .feat_addr(feat_addr), .feat_en(feat_en),
      .mac_en(mac_en), .mac_clr(mac_clr), .bias_sel(bias_sel),
      .acc_result(acc_res), .out_we(out_we), .out_idx(out_idx),
      .busy(busy), .done(done), .class_idx(class_idx)
   );

   fc_sequencer #(.MEM_LATENCY(3), .MAC_LATENCY(1)) dut3 (
      .clk(clk), .reset(reset), .start(start),
      .weight_addr(weight_addr3), .weight_en(weight_en3),
      .feat_addr(feat_addr3), .feat_en(feat_en3),
      .mac_en(mac_en3), .mac_clr(mac_clr3), .bias_sel(bias_sel3),
      .acc_result(acc_res3), .out_we(out_we3), .out_idx(out_idx3),
      .busy(busy3), .done(done3), .class_idx(class_idx3)
   );

   int n_vec;
   int n_bad;

   typedef struct {
      int j;
      bit wen; int addr; bit mac; bit clr; int bias;
      bit owe; int oidx; bit busy; bit done;
   } vec_t;
   vec_t tbl[14];

   typedef struct {
      logic signed [15:0] a0;
      logic signed [15:0] a1;
   } amx_t;
   amx_t amx[4];

   // per-cycle record of one run, index = cycles after t0
   localparam int JMAX = 130;
   logic       r_wen [0:JMAX];
   logic [6:0] r_addr[0:JMAX];
   logic       r_fen [0:JMAX];
   logic [5:0] r_faddr[0:JMAX];
   logic       r_mac [0:JMAX];
   logic       r_clr [0:JMAX];
   logic       r_bias[0:JMAX];
   logic       r_owe [0:JMAX];
   logic       r_oidx[0:JMAX];
   logic       r_busy[0:JMAX];
   logic       r_done[0:JMAX];
   logic       r_cls [0:JMAX];
   logic       q_mac [0:JMAX];
   logic       q_owe [0:JMAX];
   logic       q_done[0:JMAX];
   logic       q_cls [0:JMAX];

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic int pack(bit wen, int addr, bit mac, bit clr, int bias,
                               bit owe, int oidx, bit bsy, bit dn);
      return (int'(wen) << 16) | ((addr & 127) << 8) | (int'(mac) << 7) |
             (int'(clr) << 6) | ((bias & 1) << 5) | (int'(owe) << 4) |
             ((oidx & 1) << 3) | (int'(bsy) << 2) | (int'(dn) << 1);
   endfunction

   function automatic int outs_all();
      logic [22:0] a, b;
      a = {weight_addr, weight_en, feat_addr, feat_en, mac_en, mac_clr,
           bias_sel, out_we, out_idx, busy, done, class_idx};
      b = {weight_addr3, weight_en3, feat_addr3, feat_en3, mac_en3, mac_clr3,
           bias_sel3, out_we3, out_idx3, busy3, done3, class_idx3};
      return int'(a | b);
   endfunction

   task automatic sample(input int j);
      r_wen[j]  = weight_en;  r_addr[j] = weight_addr;
      r_fen[j]  = feat_en;    r_faddr[j] = feat_addr;
      r_mac[j]  = mac_en;     r_clr[j]  = mac_clr;
      r_bias[j] = bias_sel[0]; r_owe[j] = out_we;
      r_oidx[j] = out_idx[0]; r_busy[j] = busy;
      r_done[j] = done;       r_cls[j]  = class_idx[0];
      q_mac[j]  = mac_en3;    q_owe[j]  = out_we3;
      q_done[j] = done3;      q_cls[j]  = class_idx3[0];
   endtask

   // mode 1 adds ignored start edges at t0+10 and in the DONE cycle (t0+102)
   task automatic run_capture(input int mode);
      @(negedge clk);
      sample(0);
      start = 1'b1;
      for (int j = 1; j <= JMAX; j++) begin
         @(negedge clk);
         sample(j);
         if (mode == 1) begin
            if (j == 9 || j == 101)  start = 1'b0;
            if (j == 10 || j == 102) start = 1'b1;
         end
      end
   endtask

   task automatic check_run(input string tag, input int cls_prev, input int cls_new);
      int errs, n_mac, n_owe, n_done, n_busy, n_owe3, n_done3, first3;
      bit ew;
      foreach (tbl[i]) begin
         int j;
         j = tbl[i].j;
         chk($sformatf("%s tbl j=%0d", tag, j),
             pack(r_wen[j], int'(r_addr[j]), r_mac[j], r_clr[j], int'(r_bias[j]),
                  r_owe[j], int'(r_oidx[j]), r_busy[j], r_done[j]),
             pack(tbl[i].wen, tbl[i].addr, tbl[i].mac, tbl[i].clr, tbl[i].bias,
                  tbl[i].owe, tbl[i].oidx, tbl[i].busy, tbl[i].done));
      end
      errs = 0; n_mac = 0; n_owe = 0; n_done = 0; n_busy = 0;
      n_owe3 = 0; n_done3 = 0; first3 = -1;
      for (int j = 0; j <= JMAX; j++) begin
         ew = (j >= 1 && j <= 98);
         if (r_wen[j] != ew || r_fen[j] != ew) errs++;
         if (int'(r_addr[j]) != (ew ? j - 1 : 0)) errs++;
         if (int'(r_faddr[j]) != (ew ? (j - 1) % 49 : 0)) errs++;
         n_mac  += int'(r_mac[j]);
         n_owe  += int'(r_owe[j]);
         n_done += int'(r_done[j]);
         n_busy += int'(r_busy[j]);
         n_owe3  += int'(q_owe[j]);
         n_done3 += int'(q_done[j]);
         if (q_mac[j] && first3 < 0) first3 = j;
      end
      chk({tag, " addr_seq errors"}, errs, 0);
      chk({tag, " mac_en count"}, n_mac, 98);
      chk({tag, " out_we count"}, n_owe, 2);
      chk({tag, " done count"}, n_done, 1);
      chk({tag, " busy cycles"}, n_busy, 101);
      chk({tag, " L3 first mac_en"}, first3, 4);
      chk({tag, " L3 out_we t0+53"}, int'(q_owe[53]), 1);
      chk({tag, " L3 out_we t0+102"}, int'(q_owe[102]), 1);
      chk({tag, " L3 out_we count"}, n_owe3, 2);
      chk({tag, " L3 done t0+103"}, int'(q_done[103]), 1);
      chk({tag, " L3 done count"}, n_done3, 1);
      chk({tag, " class before done"}, int'(r_cls[101]), cls_prev);
      chk({tag, " class in done"}, int'(r_cls[102]), cls_new);
      chk({tag, " L3 class before done"}, int'(q_cls[102]), cls_prev);
      chk({tag, " L3 class in done"}, int'(q_cls[103]), cls_new);
   endtask

   initial begin
      int errs, prev, expc;
      n_vec = 0; n_bad = 0;
      reset = 1'b0; start = 1'b0; acc0 = '0; acc1 = '0;

      //           j   wen addr mac clr bias owe oidx busy done
      tbl[0]  = '{  0, 0,  0,  0, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{  1, 1,  0,  0, 0, 0, 0, 0, 1, 0};
      tbl[2]  = '{  2, 1,  1,  1, 1, 0, 0, 0, 1, 0};
      tbl[3]  = '{  3, 1,  2,  1, 0, 0, 0, 0, 1, 0};
      tbl[4]  = '{ 49, 1, 48,  1, 0, 0, 0, 0, 1, 0};
      tbl[5]  = '{ 50, 1, 49,  1, 0, 0, 0, 0, 1, 0};
      tbl[6]  = '{ 51, 1, 50,  1, 1, 1, 0, 0, 1, 0};
      tbl[7]  = '{ 52, 1, 51,  1, 0, 1, 1, 0, 1, 0};
      tbl[8]  = '{ 53, 1, 52,  1, 0, 1, 0, 0, 1, 0};
      tbl[9]  = '{ 98, 1, 97,  1, 0, 1, 0, 0, 1, 0};
      tbl[10] = '{ 99, 0,  0,  1, 0, 1, 0, 0, 1, 0};
      tbl[11] = '{100, 0,  0,  0, 0, 0, 0, 0, 1, 0};
      tbl[12] = '{101, 0,  0,  0, 0, 0, 1, 1, 1, 0};
      tbl[13] = '{102, 0,  0,  0, 0, 0, 0, 0, 0, 1};

      amx[0] = '{-16'sd5,  -16'sd5};
      amx[1] = '{16'sh0010, 16'sh0011};
      amx[2] = '{-16'sd1,  16'sd1};
      amx[3] = '{16'sh0011, 16'sh0010};

      repeat (3) @(negedge clk);
      chk("reset outputs", outs_all(), 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // basic run, start then held high
      run_capture(0);
      check_run("A", 0, 0);
      errs = 0;
      repeat (170) begin
         @(negedge clk);
         if (busy || done || busy3 || done3 || out_we || out_we3) errs++;
      end
      chk("held start retrigger", errs, 0);
      start = 1'b0;
      repeat (3) @(negedge clk);
      run_capture(0);
      check_run("B", 0, 0);
      start = 1'b0;
      repeat (3) @(negedge clk);

      // asynchronous reset mid-run at t0+40, release at t0+45 with start low
      @(negedge clk);
      start = 1'b1;
      repeat (40) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mid-run reset outputs", outs_all(), 0);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset held outputs", outs_all(), 0);
      @(negedge clk);
      reset = 1'b1;
      errs = 0;
      repeat (130) begin
         @(negedge clk);
         if (out_we || done || busy || mac_en || weight_en ||
             out_we3 || done3 || busy3 || mac_en3) errs++;
      end
      chk("post-reset quiet cycles", errs, 0);
      run_capture(0);
      check_run("C", 0, 0);
      start = 1'b0;
      repeat (3) @(negedge clk);

      // start edges during the run and in the DONE cycle are ignored
      run_capture(1);
      check_run("D", 0, 0);
      start = 1'b0;
      repeat (3) @(negedge clk);

      // argmax over node results
      prev = 0;
      foreach (amx[i]) begin
         acc0 = amx[i].a0;
         acc1 = amx[i].a1;
`ifdef FC_ARGMAX_EN
         expc = (amx[i].a1 > amx[i].a0) ? 1 : 0;
`else
         expc = 0;
`endif
         run_capture(0);
         check_run($sformatf("AMX%0d", i), prev, expc);
         prev = expc;
         start = 1'b0;
         repeat (3) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
